// File: rtl/comparatore_pkg.sv
// Shared definitions for the serial comparator: FSM state encoding and default operand width.
package comparatore_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/comparatore_seriale_cella.sv
// One-bit equality cell: z is high when both input bits match.
module cella_confronto (
  input  logic x1,
  input  logic x0,
  output logic z
);

  assign z = ~(x1 ^ x0);

endmodule

// File: rtl/comparatore_seriale.sv
// Serial LSB-first equality comparator; reports the index of the lowest mismatching bit.
// Define COMPARATORE_EARLY_EXIT_EN to finish as soon as the first mismatch is seen.
module comparatore_seriale
  import comparatore_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  output logic                 busy,
  output logic                 done,
  output logic                 equal,
  output logic [$clog2(W)-1:0] first_diff,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(W);

  // Handshake: start is accepted only in IDLE; done is a single-cycle pulse, and
  // equal/first_diff are stable from done until the next accepted start.

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q;
  logic [CW-1:0]  cnt_q;
  logic           equal_q;
  logic [CW-1:0]  first_diff_q;
  logic           bit_eq;
  logic           cnt_last;

  assign cnt_last = (cnt_q == CW'(W - 1));

  cella_confronto u_cella (
    .x1 (a_q[0]),
    .x0 (b_q[0]),
    .z  (bit_eq)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: begin
`ifdef COMPARATORE_EARLY_EXIT_EN
        if (!bit_eq || cnt_last) state_d = DONE;
`else
        if (cnt_last) state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == SHIFT);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Operands shift right so bit 0 always carries the pair under comparison.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      equal_q      <= 1'b0;
      first_diff_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q          <= a;
            b_q          <= b;
            cnt_q        <= '0;
            equal_q      <= 1'b1;
            first_diff_q <= '0;
          end
        end
        SHIFT: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          if (!cnt_last) cnt_q <= cnt_q + CW'(1);
          // equal_q still high means no earlier mismatch in this operation.
          if (!bit_eq && equal_q) begin
            equal_q      <= 1'b0;
            first_diff_q <= cnt_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign equal      = equal_q;
  assign first_diff = first_diff_q;

endmodule

// File: tb/tb_comparatore_seriale.sv
// Directed self-checking bench for comparatore_seriale (W=8), honouring COMPARATORE_EARLY_EXIT_EN.
module tb_comparatore_seriale;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, equal;
  logic [2:0]   first_diff;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected entry: {equal, first_diff[2:0], done_cycle[7:0]}
  logic [11:0] exp_q[$];

  comparatore_seriale #(.W(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .equal      (equal),
    .first_diff (first_diff),
    .dbg_state  (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic       eq;
    logic [2:0] fd;
    int         dc;
    eq = 1'b1;
    fd = 3'd0;
    dc = W + 1;
    for (int i = 0; i < W; i++) begin
      if (x[i] != y[i] && eq) begin
        eq = 1'b0;
        fd = 3'(i);
`ifdef COMPARATORE_EARLY_EXIT_EN
        dc = i + 2;
`endif
      end
    end
    return {eq, fd, 8'(dc)};
  endfunction

  // Entered at cycle 1 (just after the capture edge). Scrambles operands while busy
  // when requested, loads next_a/next_b in the done cycle, then checks the result.
  task automatic wait_result(input bit scramble, input logic [W-1:0] next_a,
                             input logic [W-1:0] next_b, output logic [11:0] e);
    int cyc;
    int nbusy;
    cyc   = 1;
    nbusy = 0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      if (scramble) begin
        a = ~a;
        b = b + 8'd1;
      end
      @(posedge clock); #1;
      cyc++;
    end
    if (cyc >= 40) check("done_timeout", 32'(cyc), 32'd0);
    e = exp_q.pop_front();
    check("done_cycle", 32'(cyc), 32'(e[7:0]));
    check("busy_cycles", 32'(nbusy), 32'(e[7:0]) - 32'd1);
    check("equal", 32'(equal), 32'(e[11]));
    check("first_diff", 32'(first_diff), 32'(e[10:8]));
    a = next_a;
    b = next_b;
    @(posedge clock); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(dbg_state), 32'd0);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, output logic [11:0] e);
    exp_q.push_back(model(x, y));
    @(negedge clock);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_result(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), e);
  endtask

  initial begin
    logic [11:0] e;
    bit          saw_done;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_equal", 32'(equal), 32'd0);
    check("rst_first_diff", 32'(first_diff), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    do_op(8'hA5, 8'hA5, e);
    do_op(8'hA5, 8'h25, e);
    do_op(8'h0F, 8'h0B, e);
    // Results hold through idle cycles while operands change.
    for (int i = 0; i < 3; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      @(posedge clock); #1;
      check("hold_equal", 32'(equal), 32'(e[11]));
      check("hold_first_diff", 32'(first_diff), 32'(e[10:8]));
    end
    do_op(8'h00, 8'hFF, e);

    // start held high, operands scrambled while busy
    exp_q.push_back(model(8'h5A, 8'h5A));
    @(negedge clock);
    a = 8'h5A;
    b = 8'h5A;
    start = 1'b1;
    @(posedge clock); #1;
    wait_result(1'b1, 8'h3C, 8'h34, e);
    exp_q.push_back(model(8'h3C, 8'h34));
    check("held_start_idle", 32'(busy), 32'd0);
    @(posedge clock); #1;
    check("held_start_recapture", 32'(busy), 32'd1);
    start = 1'b0;
    wait_result(1'b0, 8'h00, 8'h00, e);

    // reset mid-cycle during SHIFT cycle 4
    @(negedge clock);
    a = 8'hA5;
    b = 8'hA5;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_equal", 32'(equal), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_equal", 32'(equal), 32'd0);
    check("mid_rst_first_diff", 32'(first_diff), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    do_op(8'h96, 8'h16, e);

    // a few random operations for extra coverage
    for (int i = 0; i < 4; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), e);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparatore_seriale.md
COMPARATORE_SERIALE -- requirements
Module: comparatore_seriale

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits (W >= 2).
REQ-002 Port clock, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit, SHALL be the request to begin a comparison.
REQ-005 Port a, input, W bits, SHALL be the first operand, sampled only when start is accepted.
REQ-006 Port b, input, W bits, SHALL be the second operand, sampled only when start is accepted.
REQ-007 Port busy, output, 1 bit, SHALL be high while a comparison is in progress.
REQ-008 Port done, output, 1 bit, SHALL be a one-cycle completion pulse.
REQ-009 Port equal, output, 1 bit, SHALL give the result, 1 iff all compared bit pairs matched.
REQ-010 Port first_diff, output, $clog2(W) bits, SHALL give the index of the lowest mismatching bit.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL capture a and b, clear the bit counter to 0, set equal=1 and first_diff=0, and enter SHIFT.
REQ-013 In SHIFT, one bit pair per cycle SHALL be compared LSB first via the one-bit XNOR cell, and the bit counter SHALL increment by 1.
REQ-014 On the first XNOR output of 0 in an operation, the block SHALL clear equal and load the current counter value into first_diff; later mismatches SHALL NOT alter first_diff.
REQ-015 After the compare at counter W-1, the FSM SHALL move to DONE, with no counter wrap past W-1.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, followed by an unconditional return to IDLE.
REQ-017 Timing: busy=1 during cycles k+1..k+W (SHIFT); done=1 in cycle k+W+1.
REQ-018 start SHALL be ignored in SHIFT and DONE, with no re-capture and no effect on the operation in progress.
REQ-019 equal and first_diff SHALL hold their values from DONE until the next accepted start.
REQ-020 If equal=1, first_diff SHALL read 0.

Reset
REQ-021 When reset=1, the block SHALL immediately force state=IDLE, busy=0, done=0, equal=0, first_diff=0, counter=0 and operand registers=0, independent of clock.
REQ-022 A reset asserted during SHIFT or DONE SHALL abort the operation with no done pulse, after which the first edge with reset=0 and start=1 SHALL be accepted normally.

Configuration
REQ-023 With macro COMPARATORE_EARLY_EXIT_EN defined, a mismatch detected in SHIFT SHALL move the FSM directly to DONE on the next edge, so done appears at cycle k+i+2 for a lowest mismatch at bit i.
REQ-024 With COMPARATORE_EARLY_EXIT_EN undefined, every comparison SHALL take exactly W SHIFT cycles regardless of data; result values are identical in both builds.

Structure
REQ-025 Package comparatore_pkg SHALL hold the state encoding typedef (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default width constant (8).
REQ-026 The one-bit XNOR compare SHALL be a sub-module named cella_confronto (inputs x1, x0; output z), instantiated once and fed from the current bit of each shifted operand register.
REQ-027 Unused state encoding 2'b11 SHALL return to IDLE on the next edge.

Verification (W=8)
REQ-028 The bench SHALL cover: a=8'hA5, b=8'hA5, start at edge 0 -> busy cycles 1..8, done at 9, equal=1, first_diff=0.
REQ-029 The bench SHALL cover: a=8'hA5, b=8'h25 -> equal=0, first_diff=7; done at 9 in both builds.
REQ-030 The bench SHALL cover: a=8'h0F, b=8'h0B, with early exit defined -> equal=0, first_diff=2, done at cycle 4; undefined -> done at 9.
REQ-031 The bench SHALL cover: start held high continuously with a, b changed during busy -> result reflects the operands captured at edge 0; next capture on the edge after done.
REQ-032 The bench SHALL cover: reset pulsed mid-cycle during SHIFT cycle 4 -> outputs go to 0 immediately with no done; a new start then gives a correct result with done 9 cycles later.
REQ-033 The bench SHALL cover: a=8'h00, b=8'hFF -> first_diff=0 (lowest index kept), equal=0.
